// File: rtl/sb_cfg_pkg.sv
// sb_cfg_pkg: shared geometry, side-select codes, error codes and loader states.
package sb_cfg_pkg;
    localparam int N_TB  = 5;
    localparam int N_LR  = 4;
    localparam int SEL_W = 3;
    localparam int IDX_W = 3;
    localparam int E     = SEL_W + IDX_W;
    localparam int NENT  = 2 * N_TB + 2 * N_LR;
    localparam int PAY   = E * NENT;
    localparam int CNT_W = 7;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [SEL_W-1:0] SIDE_NONE   = 3'd0;
    localparam logic [SEL_W-1:0] SIDE_TOP    = 3'd1;
    localparam logic [SEL_W-1:0] SIDE_RIGHT  = 3'd2;
    localparam logic [SEL_W-1:0] SIDE_BOTTOM = 3'd3;
    localparam logic [SEL_W-1:0] SIDE_LEFT   = 3'd4;
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_PAR  = 2'b01;
    localparam logic [1:0] ERR_ILL  = 2'b10;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAR, S_CHECK} state_t;
endpackage

// File: rtl/sb_entry_check.sv
// sb_entry_check: flags a select word whose side code is unknown or whose index
// exceeds the pin count of the side it selects.
module sb_entry_check
    import sb_cfg_pkg::*;
(
    input  logic [E-1:0]   ent_i,
    input  logic [IDX_W:0] lim_tb_i,
    input  logic [IDX_W:0] lim_lr_i,
    output logic           illegal_o
);
    logic [SEL_W-1:0] sel;
    logic [IDX_W:0]   idx;
    assign sel = ent_i[SEL_W-1:0];
    assign idx = {1'b0, ent_i[E-1:SEL_W]};
    assign illegal_o = (sel > SIDE_LEFT)
        || ((sel == SIDE_TOP || sel == SIDE_BOTTOM) && idx >= lim_tb_i)
        || ((sel == SIDE_RIGHT || sel == SIDE_LEFT) && idx >= lim_lr_i);
endmodule

// File: rtl/sb_cfg_loader.sv
// sb_cfg_loader: hunts for the sync word, shifts one frame into a shadow register
// and commits it to the active switch-box selects only if parity and entries are clean.
module sb_cfg_loader
    import sb_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic              cfg_bit,
    output logic              cfg_ready,
    input  logic              cfg_abort,
    output logic [N_TB*E-1:0] cfg_top,
    output logic [N_TB*E-1:0] cfg_bottom,
    output logic [N_LR*E-1:0] cfg_left,
    output logic [N_LR*E-1:0] cfg_right,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [1:0]        err_code
);
    localparam int OFF_L = 2 * N_TB * E;
    localparam int OFF_R = OFF_L + N_LR * E;
    state_t           state_q, state_d;
    logic [7:0]       hunt_q, hunt_d, hunt_nx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAY-1:0]   shadow_q, shadow_d, act_q, act_d;
    logic             par_q, par_d, done_q, done_d, err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [NENT-1:0]  illegal;
    logic             acc, bad_par, bad_ent;
    // First bit received lands at bit 0, so entry i ends up at [6i+5:6i].
    for (genvar g = 0; g < NENT; g++) begin : g_chk
        sb_entry_check u_chk (
            .ent_i     (shadow_q[g*E +: E]),
            .lim_tb_i  ((IDX_W+1)'(N_TB)),
            .lim_lr_i  ((IDX_W+1)'(N_LR)),
            .illegal_o (illegal[g])
        );
    end
    assign cfg_ready  = state_q != S_CHECK;
    assign busy       = state_q != S_IDLE;
    assign acc        = cfg_valid & cfg_ready;
    assign hunt_nx    = {hunt_q[6:0], cfg_bit};
    assign bad_par    = par_q;
    assign bad_ent    = |illegal;
    assign cfg_top    = act_q[0 +: N_TB*E];
    assign cfg_bottom = act_q[N_TB*E +: N_TB*E];
    assign cfg_left   = act_q[OFF_L +: N_LR*E];
    assign cfg_right  = act_q[OFF_R +: N_LR*E];
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;
    assign err_code   = code_q;
    always_comb begin
        state_d  = state_q;
        hunt_d   = hunt_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        act_d    = act_q;
        par_d    = par_q;
        code_d   = code_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_abort) hunt_d = '0;
                else if (acc && hunt_nx == SYNC) begin
                    state_d = S_LOAD;
                    hunt_d  = '0;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    code_d  = ERR_NONE;
                end else if (acc) hunt_d = hunt_nx;
            end
            S_LOAD: begin
                if (cfg_abort) state_d = S_IDLE;
                else if (acc) begin
                    shadow_d = {cfg_bit, shadow_q[PAY-1:1]};
                    par_d    = par_q ^ cfg_bit;
                    state_d  = cnt_q == CNT_W'(PAY - 1) ? S_PAR : S_LOAD;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            S_PAR: begin
                if (cfg_abort) state_d = S_IDLE;
                else if (acc) begin
                    par_d   = par_q ^ cfg_bit;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                done_d  = !bad_par && !bad_ent;
                err_d   = bad_par || bad_ent;
                act_d   = err_d ? act_q : shadow_q;
                code_d  = err_d ? ((bad_par ? ERR_PAR : ERR_NONE) | (bad_ent ? ERR_ILL : ERR_NONE)) : code_q;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hunt_q   <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            act_q    <= '0;
            par_q    <= 1'b0;
            code_q   <= ERR_NONE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hunt_q   <= hunt_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            act_q    <= act_d;
            par_q    <= par_d;
            code_q   <= code_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_sb_cfg_loader.sv
// tb_sb_cfg_loader: directed frames with hand-computed select words, parity and error codes.
module tb_sb_cfg_loader;
    import sb_cfg_pkg::*;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_bit = 1'b0;
    logic              cfg_abort = 1'b0;
    logic              cfg_ready, busy, cfg_done, cfg_err;
    logic [1:0]        err_code;
    logic [N_TB*E-1:0] cfg_top, cfg_bottom;
    logic [N_LR*E-1:0] cfg_left, cfg_right;
    int checks = 0;
    int failures = 0;
    sb_cfg_loader dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_bit    (cfg_bit),
        .cfg_ready  (cfg_ready),
        .cfg_abort  (cfg_abort),
        .cfg_top    (cfg_top),
        .cfg_bottom (cfg_bottom),
        .cfg_left   (cfg_left),
        .cfg_right  (cfg_right),
        .busy       (busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .err_code   (err_code)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [PAY-1:0] ent(input int i, input logic [E-1:0] v);
        ent = PAY'(v) << (E * i);
    endfunction
    task automatic send_bit(input logic b, input int gmax);
        int n;
        if (gmax > 0) repeat ($urandom_range(0, gmax)) tick();
        cfg_valid = 1'b1;
        cfg_bit = b;
        n = 0;
        while (!cfg_ready && n < 8) begin
            tick();
            n++;
        end
        if (!cfg_ready) check("ready_timeout", 0, 1);
        tick();
        cfg_valid = 1'b0;
    endtask
    task automatic send_sync(input int gmax);
        logic [7:0] s;
        s = SYNC;
        for (int i = 7; i >= 0; i--) send_bit(s[i], gmax);
    endtask
    task automatic send_frame(input string tag, input logic [PAY-1:0] p, input logic flip,
                              input int gmax, input logic ok);
        send_sync(gmax);
        for (int i = 0; i < PAY; i++) send_bit(p[i], gmax);
        send_bit(^p ^ flip, gmax);
        check({tag, "_done_c1"}, cfg_done, 0);
        check({tag, "_err_c1"}, cfg_err, 0);
        check({tag, "_ready_check"}, cfg_ready, 0);
        tick();
        check({tag, "_done_c2"}, cfg_done, ok);
        check({tag, "_err_c2"}, cfg_err, !ok);
        tick();
        check({tag, "_done_c3"}, cfg_done, 0);
        check({tag, "_err_c3"}, cfg_err, 0);
    endtask
    task automatic check_outs(input string tag, input logic [29:0] t, input logic [29:0] b,
                              input logic [23:0] l, input logic [23:0] r);
        check({tag, "_top"}, cfg_top, t);
        check({tag, "_bottom"}, cfg_bottom, b);
        check({tag, "_left"}, cfg_left, l);
        check({tag, "_right"}, cfg_right, r);
    endtask
    initial begin
        logic [PAY-1:0] p1, p2, p3, p4, pa, p5;
        logic [7:0] s;
        p1 = ent(0, 6'b011_010);
        p2 = ent(10, 6'b100_001) | ent(5, 6'b111_000);
        p3 = ent(14, 6'b100_010);
        p4 = ent(1, 6'b000_101);
        pa = ent(3, 6'b010_011) | ent(12, 6'b001_100);
        p5 = ent(17, 6'b011_100);
        s = SYNC;
        tick();
        tick();
        rst = 1'b0;
        check_outs("reset", 0, 0, 0, 0);
        check("reset_busy", busy, 0);
        check("reset_ready", cfg_ready, 1);
        check("reset_code", err_code, 0);
        check("reset_done", cfg_done, 0);
        send_bit(1, 0);
        send_bit(1, 0);
        send_bit(0, 0);
        check("junk_idle", busy, 0);
        send_sync(0);
        check("sync_busy", busy, 1);
        for (int i = 0; i < PAY; i++) send_bit(p1[i], 0);
        send_bit(^p1, 0);
        tick();
        check("p1_done", cfg_done, 1);
        check_outs("p1", 30'h1A, 0, 0, 0);
        tick();
        check("p1_done_gone", cfg_done, 0);
        send_frame("badpar", p1 | ent(2, 6'b001_001), 1, 0, 0);
        check("badpar_code", err_code, 2'b01);
        check_outs("badpar", 30'h1A, 0, 0, 0);
        send_frame("legal4", p2, 0, 0, 1);
        check_outs("legal4", 0, 30'h38, 24'h21, 0);
        send_frame("ill", p3, 0, 0, 0);
        check("ill_code", err_code, 2'b10);
        check_outs("ill", 0, 30'h38, 24'h21, 0);
        send_frame("both", p4, 1, 0, 0);
        check("both_code", err_code, 2'b11);
        tick();
        check("code_hold", err_code, 2'b11);
        for (int i = 7; i > 0; i--) send_bit(s[i], 0);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        send_bit(s[0], 0);
        check("idle_abort_busy", busy, 0);
        send_sync(0);
        for (int i = 0; i < 50; i++) send_bit(pa[i], 0);
        cfg_abort = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit = pa[50];
        tick();
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_err", cfg_err, 0);
        check_outs("abort", 0, 30'h38, 24'h21, 0);
        send_frame("after_abort", p5, 0, 0, 1);
        check("after_abort_code", err_code, 0);
        check_outs("after_abort", 0, 0, 0, 24'h700000);
        send_frame("gaps", p1, 0, 3, 1);
        check_outs("gaps", 30'h1A, 0, 0, 0);
        send_sync(2);
        for (int i = 0; i < 40; i++) send_bit(p5[i], 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs("midrst", 0, 0, 0, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", cfg_ready, 1);
        check("midrst_code", err_code, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sb_cfg_loader.md
Name: sb_cfg_loader

Overview:
Configuration loader feeding the switch-box routing matrix directly upstream of it. It receives a serial configuration bitstream with a valid/ready handshake, hunts for a sync word and shifts one frame into a shadow register. It then checks parity and entry legality, and only then commits atomically to the active per-pin 6-bit select words that drive the matrix. A rejected frame never disturbs the active configuration.

Parameters:
N_TB, 5, pins on the top side and on the bottom side
N_LR, 4, pins on the left side and on the right side
SEL_W, 3, side-select field width (0 = undriven, 1 = top, 2 = right, 3 = bottom, 4 = left)
IDX_W, 3, source-pin index field width
SYNC, 8'hA5, frame sync word, sent MSB first

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  serial bit valid
cfg_bit  in  1  serial configuration bit
cfg_ready  out  1  loader accepts cfg_bit when cfg_valid & cfg_ready
cfg_abort  in  1  drop the current frame and return to sync hunt
cfg_top  out  N_TB*6  active words; entry i at [6i+5:6i]; bits [2:0] = side select, [5:3] = index
cfg_bottom  out  N_TB*6  as cfg_top
cfg_left  out  N_LR*6  as cfg_top
cfg_right  out  N_LR*6  as cfg_top
busy  out  1  high when state is not IDLE
cfg_done  out  1  one-cycle pulse on a successful commit
cfg_err  out  1  one-cycle pulse on a rejected frame
err_code  out  2  01 = parity, 10 = illegal entry, 11 = both; holds until the next sync match

Behaviour:
- Entry width E = SEL_W+IDX_W = 6. NENT = 2*N_TB+2*N_LR = 18. Payload = 108 bits. Bit counter is 7 bits wide.
- Frame layout: SYNC, then entries in order top0..top4, bottom0..4, left0..3, right0..3, each entry LSB first, then 1 parity bit. Total ones over payload plus parity must be even.
- Reset: all cfg_* outputs = 0 (every pin undriven). State = IDLE. Hunt register = 0. cfg_done = cfg_err = 0. err_code = 0. busy = 0. cfg_ready = 1.
- A bit is consumed only on a cycle with cfg_valid & cfg_ready. Cycles without valid leave all state unchanged, so gaps are allowed anywhere in a frame.
- IDLE: each accepted bit shifts into the 8-bit hunt register, hunt <= {hunt[6:0], bit}. When the new value equals SYNC: go to LOAD, clear the counter, clear the hunt register, clear err_code, clear the running parity.
- LOAD: shift the bit into the 108-bit shadow register and XOR it into the running parity. When the counter reaches 107, go to PAR; otherwise increment the counter.
- PAR: fold the parity bit into the running parity and go to CHECK.
- CHECK (exactly 1 cycle, cfg_ready = 0):
  - Parity is bad if the running parity is 1.
  - An entry is illegal if sel > 4, or if sel is 1 or 3 and idx >= N_TB, or if sel is 2 or 4 and idx >= N_LR. Entries with sel = 0 may carry any idx.
  - If neither fault: copy the shadow register to all cfg_* outputs and pulse cfg_done.
  - Otherwise: leave the outputs unchanged, pulse cfg_err and set err_code.
  - Either way, return to IDLE.
- Latency: the outputs and the done pulse both become visible in the second cycle after the parity bit is accepted.
- cfg_abort: in LOAD or PAR, go to IDLE with no commit and no error; the hunt register is already 0. In CHECK, ignored (the commit decision proceeds). In IDLE, clears the hunt register. Abort has priority over a bit accepted in the same cycle.
- rst mid-frame: full reset; the active configuration is cleared to 0.
- A sync pattern appearing inside the payload is treated as data.

Decomposition:
- Shared package sb_cfg_pkg:
  - side-select constants SIDE_NONE, SIDE_TOP, SIDE_RIGHT, SIDE_BOTTOM, SIDE_LEFT (0..4)
  - E, NENT
  - err_code constants
- Sub-module sb_entry_check: combinational; inputs one 6-bit entry plus the index limit; output illegal. Instantiated NENT times.

Test Plan:
- Reset -> all cfg_* = 0, busy = 0, cfg_ready = 1, err_code = 0.
- 3 junk bits, then 8'hA5, then a payload with top0 = {idx 3, sel 2} and all else 0, with correct parity -> cfg_top[5:0] = 6'b011_010, all other outputs 0, cfg_done one pulse exactly 2 cycles after the parity bit.
- Same frame with the parity bit flipped -> cfg_err pulse, err_code = 01, cfg_top unchanged from the previous commit.
- left0 = {idx 4, sel 1} (top index 4 is legal) -> commit; then a frame with right0 = {idx 4, sel 2} -> err_code = 10, no commit.
- cfg_abort asserted at payload bit 50, then a full good frame -> only the second frame commits, no cfg_err.
- Good frame delivered with random cfg_valid gaps, plus rst asserted mid-payload on a second frame -> first frame commits identically to the gap-free case; after rst all outputs = 0 and state = IDLE.
